// File: rtl/iecdrv_sd_arbiter.sv
// Round-robin arbiter sharing one host SD block-transfer port between up to
// four drive track loaders; forwards one whole-track request at a time.
module iecdrv_sd_arbiter #(
    parameter int NDRV = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NDRV*32-1:0] req_lba,
    input  logic [NDRV*6-1:0] req_sz,
    input  logic [NDRV-1:0]   req_rd,
    input  logic [NDRV-1:0]   req_wr,
    output logic [NDRV-1:0]   req_ack,
    output logic [31:0]       sd_lba,
    output logic [5:0]        sd_sz,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    output logic [1:0]        sd_drv,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

    state_t           state_reg, state_next;
    logic [31:0]      lba_reg, lba_next;
    logic [5:0]       sz_reg, sz_next;
    logic             rd_reg, rd_next;
    logic             wr_reg, wr_next;
    logic [NDRV-1:0]  ack_reg, ack_next;
    logic [1:0]       drv_reg, drv_next;
    logic             busy_reg, busy_next;
    logic [1:0]       last_reg, last_next;

    // Requests padded to four slots so selection can index any 2-bit drive.
    logic [31:0] lba_arr [4];
    logic [5:0]  sz_arr  [4];
    logic [3:0]  pend;
    logic [3:0]  wr_vec;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            if (gi < NDRV) begin : g_used
                assign lba_arr[gi] = req_lba[32*gi +: 32];
                assign sz_arr[gi]  = req_sz[6*gi +: 6];
                assign pend[gi]    = req_rd[gi] | req_wr[gi];
                assign wr_vec[gi]  = req_wr[gi];
            end else begin : g_unused
                assign lba_arr[gi] = '0;
                assign sz_arr[gi]  = '0;
                assign pend[gi]    = 1'b0;
                assign wr_vec[gi]  = 1'b0;
            end
        end
    endgenerate

    // Search starts one past the last completed grant and wraps modulo NDRV.
    logic [1:0] sel;
    logic       found;

    always_comb begin
        logic [2:0] cand;
        sel   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NDRV; k++) begin
            cand = {1'b0, last_reg} + 3'(k);
            if (cand >= 3'(NDRV)) begin
                cand = cand - 3'(NDRV);
            end
            if (!found && pend[cand[1:0]]) begin
                found = 1'b1;
                sel   = cand[1:0];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        lba_next   = lba_reg;
        sz_next    = sz_reg;
        rd_next    = rd_reg;
        wr_next    = wr_reg;
        ack_next   = ack_reg;
        drv_next   = drv_reg;
        busy_next  = busy_reg;
        last_next  = last_reg;
        unique case (state_reg)
            IDLE: begin
                if (found && !sd_ack) begin
                    lba_next   = lba_arr[sel];
                    sz_next    = sz_arr[sel];
                    drv_next   = sel;
                    busy_next  = 1'b1;
                    wr_next    = wr_vec[sel];
                    rd_next    = ~wr_vec[sel];
                    state_next = REQ;
                end
            end
            REQ: begin
                if (sd_ack) begin
                    rd_next    = 1'b0;
                    wr_next    = 1'b0;
                    ack_next   = NDRV'(1) << drv_reg;
                    state_next = XFER;
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    ack_next   = '0;
                    last_next  = drv_reg;
                    state_next = GAP;
                end
            end
            GAP: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            lba_reg   <= '0;
            sz_reg    <= '0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            ack_reg   <= '0;
            drv_reg   <= '0;
            busy_reg  <= 1'b0;
            last_reg  <= 2'(NDRV - 1);
        end else begin
            state_reg <= state_next;
            lba_reg   <= lba_next;
            sz_reg    <= sz_next;
            rd_reg    <= rd_next;
            wr_reg    <= wr_next;
            ack_reg   <= ack_next;
            drv_reg   <= drv_next;
            busy_reg  <= busy_next;
            last_reg  <= last_next;
        end
    end

    assign req_ack = ack_reg;
    assign sd_lba  = lba_reg;
    assign sd_sz   = sz_reg;
    assign sd_rd   = rd_reg;
    assign sd_wr   = wr_reg;
    assign sd_drv  = drv_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_iecdrv_sd_arbiter.sv
// Scoreboard bench for iecdrv_sd_arbiter: a host model answers strobes, the
// loaders drop their serviced level on req_ack, and a monitor checks each grant.
module tb_iecdrv_sd_arbiter;

    localparam int NDRV = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NDRV*32-1:0] req_lba = '0;
    logic [NDRV*6-1:0] req_sz = '0;
    logic [NDRV-1:0]   req_rd = '0;
    logic [NDRV-1:0]   req_wr = '0;
    logic [NDRV-1:0]   req_ack;
    logic [31:0]       sd_lba;
    logic [5:0]        sd_sz;
    logic              sd_rd;
    logic              sd_wr;
    logic              sd_ack = 1'b0;
    logic [1:0]        sd_drv;
    logic              busy;

    always #5 clk = ~clk;

    iecdrv_sd_arbiter #(.NDRV(NDRV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req_lba (req_lba),
        .req_sz  (req_sz),
        .req_rd  (req_rd),
        .req_wr  (req_wr),
        .req_ack (req_ack),
        .sd_lba  (sd_lba),
        .sd_sz   (sd_sz),
        .sd_rd   (sd_rd),
        .sd_wr   (sd_wr),
        .sd_ack  (sd_ack),
        .sd_drv  (sd_drv),
        .busy    (busy)
    );

    typedef struct {
        int          drv;
        logic [31:0] lba;
        logic [5:0]  sz;
        bit          wr;
        int          acklen;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int   host_delay = 2;
    int   host_len   = 6;
    bit   host_en    = 1'b0;
    bit   auto_drop  = 1'b1;
    logic [NDRV-1:0] ack_prev = '0;

    task automatic chk(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Every wait in the stimulus thread goes through step so the loaders can
    // drop their serviced level on the rising edge of their req_ack.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NDRV; i++) begin
            if (auto_drop && reset_n && req_ack[i] && !ack_prev[i]) begin
                if (req_wr[i]) req_wr[i] = 1'b0;
                else           req_rd[i] = 1'b0;
            end
        end
        ack_prev = req_ack;
    endtask

    task automatic set_req(input int d, input logic [31:0] lba, input logic [5:0] sz,
                           input bit rd, input bit wr);
        req_lba[32*d +: 32] = lba;
        req_sz[6*d +: 6]    = sz;
        req_rd[d]           = rd;
        req_wr[d]           = wr;
    endtask

    task automatic expect_grant(input int d, input logic [31:0] lba, input logic [5:0] sz,
                                input bit wr, input int acklen);
        exp_t e;
        e.drv = d; e.lba = lba; e.sz = sz; e.wr = wr; e.acklen = acklen;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic wait_quiet(input string name);
        int n = 0;
        while (!(!busy && !sd_ack && !sd_rd && !sd_wr && req_rd == '0 && req_wr == '0
                 && exp_q.size() == 0) && n < 400) begin
            step();
            n++;
        end
        chk(n < 400, name, $sformatf("idle not reached, busy=%0b queue=%0d", busy, exp_q.size()));
    endtask

    // Host model: answers a strobe after host_delay edges, holds sd_ack for host_len edges.
    initial begin
        forever begin
            @(negedge clk);
            if (host_en && (sd_rd || sd_wr) && !sd_ack) begin
                repeat (host_delay) @(posedge clk);
                #1 sd_ack = 1'b1;
                repeat (host_len) @(posedge clk);
                #1 sd_ack = 1'b0;
            end
        end
    end

    // Monitor: pops an expectation on every new strobe, then follows that
    // transfer through req_ack and the busy tail.
    bit   m_in_x = 1'b0;
    bit   m_wait = 1'b0;
    bit   m_prev_strobe = 1'b0;
    bit   m_prev_sdack = 1'b0;
    bit   m_stray = 1'b0;
    int   m_t = 0;
    int   m_ack_cnt = 0;
    exp_t m_cur;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_in_x = 1'b0; m_wait = 1'b0; m_prev_strobe = 1'b0; m_prev_sdack = 1'b0;
                continue;
            end
            if (m_in_x) begin
                if ((req_ack & ~(NDRV'(1) << m_cur.drv)) != '0) m_stray = 1'b1;
                if (req_ack[m_cur.drv]) m_ack_cnt++;
            end else if (req_ack != '0) begin
                checks++;
                errors++;
                $display("FAIL ack_idle: req_ack=%b outside a transfer, required 0", req_ack);
            end
            if (m_wait) begin
                m_t++;
                if (!busy || m_t > 6) begin
                    chk(m_t == 2, "busy_fall", $sformatf("busy fell %0d cycles after sd_ack, required 2", m_t));
                    chk(m_ack_cnt == m_cur.acklen, "ack_len",
                        $sformatf("drv%0d req_ack high %0d cycles, required %0d", m_cur.drv, m_ack_cnt, m_cur.acklen));
                    chk(!m_stray, "ack_onehot", $sformatf("another drive saw req_ack during drv%0d transfer", m_cur.drv));
                    m_in_x = 1'b0;
                    m_wait = 1'b0;
                end
            end
            if (m_in_x && !m_wait && m_prev_sdack && !sd_ack) begin
                m_wait = 1'b1;
                m_t = 0;
            end
            if ((sd_rd || sd_wr) && !m_prev_strobe) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: drv=%0d lba=%h rd=%0b wr=%0b, required no grant",
                             sd_drv, sd_lba, sd_rd, sd_wr);
                end else begin
                    m_cur = exp_q.pop_front();
                    chk(int'(sd_drv) == m_cur.drv && sd_lba == m_cur.lba && sd_sz == m_cur.sz &&
                        sd_wr == m_cur.wr && sd_rd == !m_cur.wr && busy,
                        "grant",
                        $sformatf("got drv=%0d lba=%h sz=%0d rd=%0b wr=%0b busy=%0b, required drv=%0d lba=%h sz=%0d wr=%0b busy=1",
                                  sd_drv, sd_lba, sd_sz, sd_rd, sd_wr, busy,
                                  m_cur.drv, m_cur.lba, m_cur.sz, m_cur.wr));
                    $display("grant drv=%0d lba=%h sz=%0d wr=%0b", sd_drv, sd_lba, sd_sz, sd_wr);
                    m_in_x = 1'b1; m_ack_cnt = 0; m_stray = 1'b0; m_wait = 1'b0;
                end
            end
            m_prev_strobe = sd_rd || sd_wr;
            m_prev_sdack  = sd_ack;
        end
    end

    task automatic check_all_zero(input string tag);
        chk(req_ack == '0, {tag, "_req_ack"}, $sformatf("req_ack=%b, required 0", req_ack));
        chk(sd_rd == 1'b0, {tag, "_sd_rd"}, $sformatf("sd_rd=%0b, required 0", sd_rd));
        chk(sd_wr == 1'b0, {tag, "_sd_wr"}, $sformatf("sd_wr=%0b, required 0", sd_wr));
        chk(busy == 1'b0, {tag, "_busy"}, $sformatf("busy=%0b, required 0", busy));
        chk(sd_drv == 2'd0, {tag, "_sd_drv"}, $sformatf("sd_drv=%0d, required 0", sd_drv));
        chk(sd_lba == 32'd0, {tag, "_sd_lba"}, $sformatf("sd_lba=%h, required 0", sd_lba));
        chk(sd_sz == 6'd0, {tag, "_sd_sz"}, $sformatf("sd_sz=%0d, required 0", sd_sz));
    endtask

    initial begin
        int n;
        bit bad;

        step();
        step();
        check_all_zero("reset");
        reset_n = 1'b1;
        host_en = 1'b1;

        // Single read with the host answering 4 cycles late for 10 cycles.
        host_delay = 4; host_len = 10;
        expect_grant(0, 32'h15, 6'd20, 1'b0, 10);
        set_req(0, 32'h15, 6'd20, 1'b1, 1'b0);
        wait_quiet("single_read_done");

        // Both drives from reset: drive0 first, then drive1, then drive0 again.
        do_reset();
        host_delay = 2; host_len = 6;
        expect_grant(0, 32'h100, 6'd3, 1'b0, 6);
        expect_grant(1, 32'h200, 6'd5, 1'b0, 6);
        set_req(0, 32'h100, 6'd3, 1'b1, 1'b0);
        set_req(1, 32'h200, 6'd5, 1'b1, 1'b0);
        n = 0;
        while (!req_ack[1] && n < 100) begin step(); n++; end
        chk(n < 100, "wait_ack1", "req_ack[1] never rose");
        expect_grant(0, 32'h300, 6'd8, 1'b0, 6);
        set_req(0, 32'h300, 6'd8, 1'b1, 1'b0);
        wait_quiet("simul_done");

        // Write wins over a simultaneous read; the read follows with a new lba.
        host_len = 4;
        expect_grant(1, 32'h1F8, 6'd10, 1'b1, 4);
        set_req(1, 32'h1F8, 6'd10, 1'b1, 1'b1);
        n = 0;
        while (req_wr[1] && n < 100) begin step(); n++; end
        chk(n < 100, "wait_wr_drop", "write was never acknowledged");
        expect_grant(1, 32'h2A0, 6'd10, 1'b0, 4);
        set_req(1, 32'h2A0, 6'd10, 1'b1, 1'b0);
        wait_quiet("write_prio_done");

        // One-cycle sd_ack pulse.
        host_delay = 1; host_len = 1;
        expect_grant(1, 32'h33, 6'd0, 1'b0, 1);
        set_req(1, 32'h33, 6'd0, 1'b1, 1'b0);
        wait_quiet("one_cycle_done");

        // Reset in XFER while the host keeps sd_ack high.
        host_delay = 0; host_len = 12; auto_drop = 1'b0;
        expect_grant(0, 32'h44, 6'd2, 1'b0, 0);
        set_req(0, 32'h44, 6'd2, 1'b1, 1'b0);
        n = 0;
        while (!req_ack[0] && n < 100) begin step(); n++; end
        chk(n < 100, "wait_ack0", "req_ack[0] never rose");
        step();
        step();
        reset_n = 1'b0;
        step();
        check_all_zero("midreset");
        chk(sd_ack == 1'b1, "midreset_host", "host dropped sd_ack before the hold-off window");
        reset_n = 1'b1;
        host_len = 4;
        auto_drop = 1'b1;
        expect_grant(0, 32'h44, 6'd2, 1'b0, 4);
        bad = 1'b0;
        n = 0;
        while (sd_ack && n < 50) begin
            if (sd_rd || sd_wr || busy) bad = 1'b1;
            step();
            n++;
        end
        chk(!bad && n >= 5 && n < 50, "holdoff",
            $sformatf("grant seen while sd_ack high=%0b after %0d cycles, required none", bad, n));
        wait_quiet("midreset_done");

        // Drive0 abandons its request while in REQ.
        host_delay = 3; host_len = 3;
        expect_grant(0, 32'h55, 6'd1, 1'b0, 3);
        set_req(0, 32'h55, 6'd1, 1'b1, 1'b0);
        n = 0;
        while (!sd_rd && n < 100) begin step(); n++; end
        chk(n < 100, "wait_rd", "sd_rd never rose");
        req_rd[0] = 1'b0;
        wait_quiet("abandon_done");
        repeat (10) step();
        chk(!busy && !sd_rd && !sd_wr, "no_regrant",
            $sformatf("busy=%0b sd_rd=%0b sd_wr=%0b after abandon, required all 0", busy, sd_rd, sd_wr));

        chk(exp_q.size() == 0, "queue_empty", $sformatf("%0d grants never seen, required 0", exp_q.size()));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
